// File: rtl/pipe_pkg.sv
// Shared types and ID/EX bundle layout for pipeline stage registers.
// Pack/unpack helpers keep the control field order in one place.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   localparam int unsigned IDEX_CTRL_W = 10;
   localparam int unsigned IDEX_DATA_W = 165;

   // Control bit positions inside the ID/EX control bundle.
   localparam int unsigned IDEX_JAL_BIT    = 0;
   localparam int unsigned IDEX_SHIFT_BIT  = 1;
   localparam int unsigned IDEX_ALUIMM_BIT = 2;
   localparam int unsigned IDEX_ALUC_LSB   = 3;
   localparam int unsigned IDEX_ALUC_W     = 4;
   localparam int unsigned IDEX_WMEM_BIT   = 7;
   localparam int unsigned IDEX_M2REG_BIT  = 8;
   localparam int unsigned IDEX_WREG_BIT   = 9;

   // Data bundle layout: a, b, imm, pc4, sa (32 bits each) then rn.
   localparam int unsigned IDEX_WORD_W = 32;
   localparam int unsigned IDEX_RN_W   = 5;
   localparam int unsigned IDEX_RN_LSB = 0;
   localparam int unsigned IDEX_SA_LSB  = IDEX_RN_LSB + IDEX_RN_W;
   localparam int unsigned IDEX_PC4_LSB = IDEX_SA_LSB + IDEX_WORD_W;
   localparam int unsigned IDEX_IMM_LSB = IDEX_PC4_LSB + IDEX_WORD_W;
   localparam int unsigned IDEX_B_LSB   = IDEX_IMM_LSB + IDEX_WORD_W;
   localparam int unsigned IDEX_A_LSB   = IDEX_B_LSB + IDEX_WORD_W;

   typedef struct packed {
      logic       wreg;
      logic       m2reg;
      logic       wmem;
      logic [3:0] aluc;
      logic       aluimm;
      logic       shift;
      logic       jal;
   } idex_ctrl_t;

   function automatic logic [IDEX_CTRL_W-1:0] idex_ctrl_pack(input idex_ctrl_t c);
      logic [IDEX_CTRL_W-1:0] v;
      v = '0;
      v[IDEX_JAL_BIT]                         = c.jal;
      v[IDEX_SHIFT_BIT]                       = c.shift;
      v[IDEX_ALUIMM_BIT]                      = c.aluimm;
      v[IDEX_ALUC_LSB +: IDEX_ALUC_W]         = c.aluc;
      v[IDEX_WMEM_BIT]                        = c.wmem;
      v[IDEX_M2REG_BIT]                       = c.m2reg;
      v[IDEX_WREG_BIT]                        = c.wreg;
      return v;
   endfunction

   function automatic idex_ctrl_t idex_ctrl_unpack(input logic [IDEX_CTRL_W-1:0] v);
      idex_ctrl_t c;
      c.jal    = v[IDEX_JAL_BIT];
      c.shift  = v[IDEX_SHIFT_BIT];
      c.aluimm = v[IDEX_ALUIMM_BIT];
      c.aluc   = v[IDEX_ALUC_LSB +: IDEX_ALUC_W];
      c.wmem   = v[IDEX_WMEM_BIT];
      c.m2reg  = v[IDEX_M2REG_BIT];
      c.wreg   = v[IDEX_WREG_BIT];
      return c;
   endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a two-entry skid buffer, flush-to-bubble
// and a saturating stall counter. in_ready is registered (never a function of out_ready).
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W              = IDEX_CTRL_W,
   parameter int unsigned DATA_W              = IDEX_DATA_W,
   parameter bit          ZERO_DATA_ON_BUBBLE = 1'b0,
   parameter int unsigned CNT_W               = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   skid_state_t       state_q, state_d;
   logic              in_ready_q;
   logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
   logic [DATA_W-1:0] main_data_q, skid_data_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic acc, pop, main_valid;
   logic load_main_in, load_main_skid, load_skid;
   logic stall_inc;

   assign main_valid = (state_q != EMPTY);
   assign acc        = in_valid & in_ready_q & ~flush;
   assign pop        = main_valid & out_ready;
   assign stall_inc  = main_valid & ~out_ready;

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (acc) begin
                  load_main_in = 1'b1;
                  state_d      = ONE;
               end
            end
            ONE: begin
               if (acc && pop) begin
                  load_main_in = 1'b1;
               end else if (acc) begin
                  load_skid = 1'b1;
                  state_d   = TWO;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               // in_ready is low here, so only the skid entry can move up.
               if (pop) begin
                  load_main_skid = 1'b1;
                  state_d        = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != TWO);
         if (load_main_in) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
         end else if (load_main_skid) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
         end
         if (load_skid) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
         end
         if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid;
   // Bubbles must never carry wreg/wmem downstream.
   assign out_ctrl  = main_valid ? main_ctrl_q : '0;
   assign out_data  = (ZERO_DATA_ON_BUBBLE && !main_valid) ? '0 : main_data_q;
   assign stall_cnt = stall_cnt_q;

endmodule
